// File: rtl/ysyx_23060075_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU fetches and LSU accesses.
// One transaction in flight; the captured response is held until its owner takes it.
module ysyx_23060075_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_mask,
    input  logic                  lsu_wen,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_mask,
    output logic                  mem_wen,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] mask;
    logic                  wen;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  grant_ifu;
    logic                  grant_lsu;
    logic                  owner_ready;

    // owner/last_grant: 0 = IFU, 1 = LSU; a tie goes to whoever was not served last
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && state == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_ifu = last_grant;
                grant_lsu = !last_grant;
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign owner_ready = owner ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            mask       <= '0;
            wen        <= 1'b0;
            rdata      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        addr  <= ifu_addr;
                        wdata <= '0;
                        mask  <= '1;
                        wen   <= 1'b0;
                        owner <= 1'b0;
                        state <= REQ;
                    end else if (grant_lsu) begin
                        addr  <= lsu_addr;
                        wdata <= lsu_wdata;
                        mask  <= lsu_mask;
                        wen   <= lsu_wen;
                        owner <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        rdata <= mem_rdata;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = !rst && state == REQ;
    assign ifu_resp_valid = !rst && state == RESP && !owner;
    assign lsu_resp_valid = !rst && state == RESP && owner;
    assign mem_addr       = addr;
    assign mem_wdata      = wdata;
    assign mem_mask       = mask;
    assign mem_wen        = wen;
    assign ifu_rdata      = rdata;
    assign lsu_rdata      = rdata;

endmodule

// File: tb/tb_ysyx_23060075_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: transaction-level model plus directed
// scenarios and a randomized run with a latency-varying memory.
module tb_ysyx_23060075_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready = 1'b1;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_mask = '0;
    logic        lsu_wen = 1'b0;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready = 1'b1;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_wen;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    ysyx_23060075_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_wen(lsu_wen), .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_wen(mem_wen), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level view: is a transaction open, who owns it, has memory
    // taken the request yet, has data come back yet.
    typedef struct {
        bit          busy;
        bit          owner;
        bit          last;
        bit          issued;
        bit          have;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        bit          wen;
        logic [31:0] data;
    } model_t;

    model_t m, mn;

    bit          pend = 0;
    int          delay = 0;
    int          resp_delay = 0;
    logic [31:0] mem_data_next = '0;
    bit          spurious_en = 0;
    bit          mem_fire;
    bit          e_ifu_rdy, e_lsu_rdy;

    task automatic settle();
        mem_resp_valid = 1'b0;
        if (pend && delay == 0)
            mem_resp_valid = 1'b1;
        else if (spurious_en && !pend && (!m.busy || m.have) && $urandom_range(0, 7) == 0)
            mem_resp_valid = 1'b1;
        mem_rdata = mem_resp_valid ? mem_data_next : (32'hBAD0_0000 ^ $urandom);
        #1;
        e_ifu_rdy = !m.busy && ifu_req_valid && (!lsu_req_valid || m.last);
        e_lsu_rdy = !m.busy && lsu_req_valid && (!ifu_req_valid || !m.last);
        if (rst) begin
            check("rst_ifu_req_ready", ifu_req_ready, 0);
            check("rst_lsu_req_ready", lsu_req_ready, 0);
            check("rst_mem_req_valid", mem_req_valid, 0);
            check("rst_ifu_resp_valid", ifu_resp_valid, 0);
            check("rst_lsu_resp_valid", lsu_resp_valid, 0);
        end else begin
            check("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
            check("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
            check("mem_req_valid", mem_req_valid, m.busy && !m.issued);
            check("ifu_resp_valid", ifu_resp_valid, m.busy && m.have && !m.owner);
            check("lsu_resp_valid", lsu_resp_valid, m.busy && m.have && m.owner);
            check("mem_addr", mem_addr, m.addr);
            check("mem_wdata", mem_wdata, m.wdata);
            check("mem_mask", mem_mask, m.mask);
            check("mem_wen", mem_wen, m.wen);
            check("ifu_rdata", ifu_rdata, m.data);
            check("lsu_rdata", lsu_rdata, m.data);
        end
        mem_fire = mem_req_valid && mem_req_ready;
        mn = m;
        if (rst) begin
            mn = '{default: '0};
            mn.last = 1'b1;
        end else if (!m.busy) begin
            if (e_ifu_rdy) begin
                mn.busy = 1; mn.owner = 0; mn.addr = ifu_addr;
                mn.wdata = '0; mn.mask = 4'hF; mn.wen = 0;
            end else if (e_lsu_rdy) begin
                mn.busy = 1; mn.owner = 1; mn.addr = lsu_addr;
                mn.wdata = lsu_wdata; mn.mask = lsu_mask; mn.wen = lsu_wen;
            end
        end else if (!m.issued) begin
            if (mem_req_ready) mn.issued = 1;
        end else if (!m.have) begin
            if (mem_resp_valid) begin
                mn.have = 1;
                mn.data = mem_rdata;
            end
        end else if (m.owner ? lsu_resp_ready : ifu_resp_ready) begin
            mn.busy = 0; mn.issued = 0; mn.have = 0; mn.last = m.owner;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m = mn;
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            if (delay == 0) pend = 0;
            else delay--;
        end else if (mem_fire) begin
            pend = 1;
            delay = resp_delay;
        end
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic wait_accept(input bit lsu, input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            settle();
            ok = lsu ? (lsu_req_valid && lsu_req_ready) : (ifu_req_valid && ifu_req_ready);
            advance();
        end
        check(lsu ? "lsu_accept_in_time" : "ifu_accept_in_time", ok, 1);
        if (lsu) lsu_req_valid = 0;
        else ifu_req_valid = 0;
    endtask

    task automatic wait_resp(input bit lsu, input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            settle();
            ok = lsu ? (lsu_resp_valid && lsu_resp_ready) : (ifu_resp_valid && ifu_resp_ready);
            advance();
        end
        check(lsu ? "lsu_resp_in_time" : "ifu_resp_in_time", ok, 1);
    endtask

    initial begin
        bit got;
        bit ifu_drop, lsu_drop;
        m = '{default: '0};
        m.last = 1'b1;

        // Reset with both requesters already asking
        rst = 1; ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'h1;
        lsu_mask = 4'hF; lsu_wen = 0;
        step();
        step();
        rst = 0;

        // Simultaneous requests: IFU first, LSU next, then IFU again
        settle();
        check("post_rst_rdata", ifu_rdata, 32'h0);
        check("post_rst_mem_addr", mem_addr, 32'h0);
        check("rr1_ifu_ready", ifu_req_ready, 1);
        check("rr1_lsu_ready", lsu_req_ready, 0);
        advance();
        ifu_req_valid = 0;
        mem_data_next = 32'h1111_0000;
        wait_resp(0, 10);
        settle();
        check("rr2_lsu_ready", lsu_req_ready, 1);
        advance();
        lsu_req_valid = 0;
        wait_resp(1, 10);
        ifu_req_valid = 1; lsu_req_valid = 1;
        settle();
        check("rr3_ifu_ready", ifu_req_ready, 1);
        check("rr3_lsu_ready", lsu_req_ready, 0);
        advance();
        ifu_req_valid = 0;
        wait_resp(0, 10);
        wait_accept(1, 3);
        wait_resp(1, 10);

        // Minimum-latency single fetch
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        mem_data_next = 32'h0000_0413; resp_delay = 0;
        settle();
        check("f_T_ready", ifu_req_ready, 1);
        advance();
        ifu_req_valid = 0;
        settle();
        check("f_T1_mem_req_valid", mem_req_valid, 1);
        check("f_T1_mem_addr", mem_addr, 32'h8000_0000);
        check("f_T1_mem_mask", mem_mask, 4'hF);
        advance();
        settle();
        check("f_T2_resp_valid", ifu_resp_valid, 0);
        advance();
        settle();
        check("f_T3_resp_valid", ifu_resp_valid, 1);
        check("f_T3_rdata", ifu_rdata, 32'h0000_0413);
        check("f_T3_lsu_resp", lsu_resp_valid, 0);
        advance();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        settle();
        check("f_T4_idle_ready", ifu_req_ready, 1);
        advance();
        ifu_req_valid = 0;
        wait_resp(0, 10);

        // Store with partial strobes
        lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF;
        lsu_mask = 4'h3; lsu_wen = 1; mem_data_next = 32'hCAFE_0001;
        wait_accept(1, 4);
        settle();
        check("st_mem_wen", mem_wen, 1);
        check("st_mem_mask", mem_mask, 4'h3);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_mem_addr", mem_addr, 32'h8000_0100);
        advance();
        wait_resp(1, 10);

        // Memory stalls the request for 5 cycles
        mem_req_ready = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        mem_data_next = 32'h0000_0040;
        wait_accept(0, 4);
        lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; lsu_mask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_mem_req_valid", mem_req_valid, 1);
            check("stall_mem_addr", mem_addr, 32'h8000_0040);
            check("stall_lsu_ready", lsu_req_ready, 0);
            check("stall_ifu_ready", ifu_req_ready, 0);
            advance();
        end
        mem_req_ready = 1;
        wait_resp(0, 10);

        // LSU holds off its response for 3 cycles
        lsu_resp_ready = 0; mem_data_next = 32'h1234_5678;
        wait_accept(1, 3);
        ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            settle();
            got = lsu_resp_valid;
            if (!got) advance();
        end
        check("hold_resp_seen", got, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) settle();
            check("hold_lsu_resp_valid", lsu_resp_valid, 1);
            check("hold_lsu_rdata", lsu_rdata, 32'h1234_5678);
            check("hold_ifu_ready", ifu_req_ready, 0);
            advance();
        end
        lsu_resp_ready = 1;
        wait_resp(1, 4);
        wait_accept(0, 4);
        wait_resp(0, 10);

        // Reset while waiting on memory drops the transaction
        ifu_req_valid = 1; ifu_addr = 32'h8000_0500; resp_delay = 2;
        wait_accept(0, 4);
        step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("rst_wait_no_resp", ifu_resp_valid, 0);
            check("rst_wait_no_req", mem_req_valid, 0);
            advance();
        end

        // Randomized traffic
        spurious_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
                ifu_req_valid = 1;
                ifu_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
                lsu_req_valid = 1;
                lsu_addr = $urandom;
                lsu_wdata = $urandom;
                lsu_mask = 4'($urandom_range(1, 15));
                lsu_wen = 1'($urandom_range(0, 1));
            end
            ifu_resp_ready = 1'($urandom_range(0, 1));
            lsu_resp_ready = 1'($urandom_range(0, 1));
            mem_req_ready = $urandom_range(0, 3) != 0;
            resp_delay = $urandom_range(0, 2);
            mem_data_next = $urandom;
            rst = $urandom_range(0, 299) == 0;
            settle();
            ifu_drop = ifu_req_valid && ifu_req_ready;
            lsu_drop = lsu_req_valid && lsu_req_ready;
            advance();
            if (ifu_drop) ifu_req_valid = 0;
            if (lsu_drop) lsu_req_valid = 0;
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
